// File: rtl/shift_sequencer.sv
// Shift sequencer: drives an external W-bit universal shift register through
// one command: a parallel load of the operand, then N shift cycles with the
// correct serial-in bit. Logical and rotate shifts are supported in both
// directions. Register modes {l,r}: 00 hold, 01 toward MSB, 10 toward LSB,
// 11 parallel load.
//
// Handshake: start is a one-cycle command strobe. It is sampled only while
// busy=0 (IDLE). Once a command is accepted, busy stays high through LOAD,
// SHIFT and DONE, and start is ignored for that whole time, including the DONE
// cycle. done pulses for exactly one cycle, and the result is on q from that
// cycle onward.
module shift_sequencer #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          c,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amt,
    input  logic          fill,
    input  logic [W-1:0]  din,
    input  logic [W-1:0]  q,
    output logic          l,
    output logic          r,
    output logic          i,
    output logic [W-1:0]  d,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } stateT;

    localparam logic [AW-1:0] WIDTH_CNT = AW'(W);

    stateT         state;
    stateT         nextState;
    logic [AW-1:0] count;
    logic [AW-1:0] startCount;
    logic [1:0]    opReg;
    logic          fillReg;
    logic [W-1:0]  dinReg;

    // Effective count: logical shifts saturate at W, rotates wrap modulo W.
    always_comb begin
        startCount = '0;
        if (op[1]) begin
            startCount = amt % WIDTH_CNT;
        end else if (amt > WIDTH_CNT) begin
            startCount = WIDTH_CNT;
        end else begin
            startCount = amt;
        end
    end

    // State register, shift counter and captured command fields.
    always_ff @(posedge c) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            opReg   <= 2'b00;
            fillReg <= 1'b0;
            dinReg  <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                count   <= startCount;
                opReg   <= op;
                fillReg <= fill;
                dinReg  <= din;
            end else if (state == SHIFT) begin
                count <= count - 1'b1;
            end
        end
    end

    // Next-state and register controls. While rst is high every control is
    // forced idle, so no load or shift reaches the register during reset.
    always_comb begin
        nextState = state;
        l         = 1'b0;
        r         = 1'b0;
        d         = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nextState = LOAD;
                    end
                end
                LOAD: begin
                    l    = 1'b1;
                    r    = 1'b1;
                    d    = dinReg;
                    busy = 1'b1;
                    nextState = (count != '0) ? SHIFT : DONE;
                end
                SHIFT: begin
                    d    = dinReg;
                    busy = 1'b1;
                    // opReg[0]=1 means a right (toward LSB) operation.
                    if (opReg[0]) begin
                        l = 1'b1;
                    end else begin
                        r = 1'b1;
                    end
                    if (count <= 1) begin
                        nextState = DONE;
                    end
                end
                DONE: begin
                    d    = dinReg;
                    busy = 1'b1;
                    done = 1'b1;
                    nextState = IDLE;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // Serial-in: fill for logical ops, the bit falling off the far end for
    // rotates. Driven in every state so it is never X.
    always_comb begin
        i = 1'b0;
        if (!rst) begin
            if (opReg[1]) begin
                i = opReg[0] ? q[0] : q[W-1];
            end else begin
                i = fillReg;
            end
        end
    end

endmodule
